// File: rtl/ex_merge_queue_pkg.sv
// Shared types and sizing helpers for the execute-to-writeback merge queue.
// The merged message layout is {pc, waddr, wdata, wen, seq_num, preg, ppreg}.
package ex_merge_queue_pkg;

    localparam int SEQ_NUM_BITS_DFLT   = 8;
    localparam int PHYS_ADDR_BITS_DFLT = 6;

    typedef struct packed {
        logic [31:0]                    pc;
        logic [4:0]                     waddr;
        logic [31:0]                    wdata;
        logic                           wen;
        logic [SEQ_NUM_BITS_DFLT-1:0]   seq_num;
        logic [PHYS_ADDR_BITS_DFLT-1:0] preg;
        logic [PHYS_ADDR_BITS_DFLT-1:0] ppreg;
    } ex_msg_t;

    function automatic int msg_bits(input int seq_bits, input int preg_bits);
        return 32 + 5 + 32 + 1 + seq_bits + 2 * preg_bits;
    endfunction

    // Width of the round-robin pointer / channel index; never zero.
    function automatic int rr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_merge_queue_arb.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; rr_ptr moves
// past the winner only when the grant is consumed (adv).
module ex_merge_queue_arb
    import ex_merge_queue_pkg::*;
#(
    parameter int p_num = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [p_num-1:0]          req,
    input  logic                      adv,
    output logic [p_num-1:0]          grant,
    output logic [rr_bits(p_num)-1:0] grant_idx,
    output logic                      any
);
    localparam int IW = rr_bits(p_num);

    logic [IW-1:0] rr_ptr;

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < p_num; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= p_num) j = j - p_num;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            rr_ptr <= '0;
        else if (adv && any)
            rr_ptr <= (int'(grant_idx) == p_num - 1) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/ex_merge_queue_fifo.sv
// Per-channel result FIFO with occupancy count and synchronous clear.
module ex_merge_queue_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [p_width-1:0]         wdata,
    output logic [p_width-1:0]         rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(p_depth+1)-1:0] count
);
    localparam int AW = $clog2(p_depth);
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      cnt;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(p_depth));
    assign count = cnt;

endmodule

// File: rtl/ex_merge_queue.sv
// Merges per-execute-unit results into one writeback stream: a bypassable
// FIFO per channel feeding a round-robin arbiter, with pipeline-squash flush.
module ex_merge_queue
    import ex_merge_queue_pkg::*;
#(
    parameter int p_num_chan       = 2,
    parameter int p_depth          = 4,
    parameter int p_seq_num_bits   = SEQ_NUM_BITS_DFLT,
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS_DFLT
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          flush,
    input  logic [p_num_chan-1:0]                                         in_val,
    output logic [p_num_chan-1:0]                                         in_rdy,
    input  logic [p_num_chan-1:0][msg_bits(p_seq_num_bits, p_phys_addr_bits)-1:0] in_msg,
    output logic                                                          out_val,
    input  logic                                                          out_rdy,
    output logic [msg_bits(p_seq_num_bits, p_phys_addr_bits)-1:0]         out_msg,
    output logic [p_num_chan-1:0][$clog2(p_depth+1)-1:0]                  occ,
    output logic [rr_bits(p_num_chan)-1:0]                                grant_chan
);
    localparam int MSG_W = msg_bits(p_seq_num_bits, p_phys_addr_bits);

    logic [p_num_chan-1:0]            empty, full, head_val, win, push, pop;
    logic [p_num_chan-1:0][MSG_W-1:0] fifo_q, head_msg;

    for (genvar g = 0; g < p_num_chan; g++) begin : g_chan
        ex_merge_queue_fifo #(
            .p_width (MSG_W),
            .p_depth (p_depth)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .wdata (in_msg[g]),
            .rdata (fifo_q[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .count (occ[g])
        );

        // Masking the heads during flush also kills win, hence pop and out_val.
        assign head_val[g] = !flush && (!empty[g] || in_val[g]);
        assign head_msg[g] = empty[g] ? in_msg[g] : fifo_q[g];
        assign in_rdy[g]   = !flush && (!full[g] || (win[g] && out_rdy));
        assign push[g]     = in_val[g] && in_rdy[g] && !(empty[g] && win[g] && out_rdy);
        assign pop[g]      = !empty[g] && win[g] && out_rdy;
    end

    ex_merge_queue_arb #(
        .p_num (p_num_chan)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .req       (head_val),
        .adv       (out_rdy),
        .grant     (win),
        .grant_idx (grant_chan),
        .any       (out_val)
    );

    // One-hot AND-OR mux avoids indexing past p_num_chan for non-power-of-two counts.
    always_comb begin
        out_msg = '0;
        for (int i = 0; i < p_num_chan; i++)
            if (win[i]) out_msg = out_msg | head_msg[i];
    end

endmodule

// File: tb/tb_ex_merge_queue.sv
// Self-checking bench for ex_merge_queue: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_ex_merge_queue;
    import ex_merge_queue_pkg::*;

    localparam int N     = 3;
    localparam int D     = 4;
    localparam int SEQ   = 8;
    localparam int PREG  = 6;
    localparam int MSG_W = msg_bits(SEQ, PREG);
    localparam int OCC_W = $clog2(D + 1);
    localparam int RR_W  = rr_bits(N);

    typedef logic [MSG_W-1:0] msg_t;

    logic                       clk, rst, flush, out_val, out_rdy;
    logic [N-1:0]               in_val, in_rdy;
    logic [N-1:0][MSG_W-1:0]    in_msg;
    msg_t                       out_msg;
    logic [N-1:0][OCC_W-1:0]    occ;
    logic [RR_W-1:0]            grant_chan;

    ex_merge_queue #(
        .p_num_chan       (N),
        .p_depth          (D),
        .p_seq_num_bits   (SEQ),
        .p_phys_addr_bits (PREG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_msg     (in_msg),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .occ        (occ),
        .grant_chan (grant_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per channel plus a priority pointer.
    msg_t         q [N][$];
    int           rr;
    logic         exp_val;
    int           exp_win;
    msg_t         exp_msg;
    logic [N-1:0] exp_rdy;

    int n_checks = 0;
    int n_fail   = 0;
    int msg_cnt  = 0;
    int cyc      = 0;

    function automatic msg_t mk_msg(input int ch);
        msg_t m;
        m = MSG_W'({$urandom, $urandom, $urandom});
        m[MSG_W-1 -: 32] = {8'(ch), 24'(msg_cnt)};
        msg_cnt++;
        return m;
    endfunction

    task automatic model_eval();
        exp_val = 1'b0;
        exp_win = -1;
        exp_msg = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (exp_win < 0 && !flush && (q[j].size() > 0 || in_val[j])) begin
                exp_win = j;
                exp_val = 1'b1;
                exp_msg = (q[j].size() > 0) ? q[j][0] : in_msg[j];
            end
        end
        for (int i = 0; i < N; i++)
            exp_rdy[i] = !flush && (q[i].size() < D || (exp_win == i && out_rdy));
    endtask

    task automatic model_commit();
        if (rst || flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                logic taken, bypassed;
                taken    = exp_win == i && out_rdy;
                bypassed = taken && q[i].size() == 0;
                if (taken && q[i].size() > 0) void'(q[i].pop_front());
                if (in_val[i] && exp_rdy[i] && !bypassed) q[i].push_back(in_msg[i]);
            end
            if (exp_val && out_rdy) rr = (exp_win + 1) % N;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_eval();
    endtask

    task automatic to_next();
        model_commit();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_val = '0; out_rdy = 1'b0; in_msg = '0;
        repeat (2) begin to_neg(); to_next(); end
        rst = 1'b0;
        to_neg();
        n_checks++; if (occ !== '0) begin n_fail++; $display("FAIL reset_occ got=%h exp=0", occ); end
        n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        n_checks++; if (grant_chan !== '0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", grant_chan); end
        n_checks++; if (in_rdy !== '1) begin n_fail++; $display("FAIL reset_in_rdy got=%b exp=%b", in_rdy, {N{1'b1}}); end
        to_next();
    endtask

    task automatic test_bypass();
        msg_t m;
        out_rdy = 1'b1;
        for (int t = 0; t < 10; t++) begin
            m = mk_msg(0);
            in_val = 3'b001; in_msg = '0; in_msg[0] = m;
            to_neg();
            n_checks++; if (out_val !== 1'b1 || out_msg !== m)
                begin n_fail++; $display("FAIL bypass_msg t=%0d got=%b/%h exp=1/%h", t, out_val, out_msg, m); end
            n_checks++; if (grant_chan !== 0 || occ[0] !== '0)
                begin n_fail++; $display("FAIL bypass_grant_occ t=%0d got=%0d/%0d exp=0/0", t, grant_chan, occ[0]); end
            to_next();
        end
        in_val = '0;
    endtask

    task automatic test_round_robin();
        int cnt [N];
        flush = 1'b1; to_neg(); to_next(); flush = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        out_rdy = 1'b1;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) in_msg[i] = mk_msg(i);
            in_val = '1;
            to_neg();
            n_checks++; if (out_val !== 1'b1 || int'(grant_chan) !== t % N)
                begin n_fail++; $display("FAIL rr_order t=%0d got=%0d exp=%0d", t, grant_chan, t % N); end
            n_checks++; if (out_msg !== exp_msg)
                begin n_fail++; $display("FAIL rr_msg t=%0d got=%h exp=%h", t, out_msg, exp_msg); end
            if (grant_chan < N) cnt[grant_chan]++;
            to_next();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++; if (cnt[i] !== 4) begin n_fail++; $display("FAIL rr_share ch=%0d got=%0d exp=4", i, cnt[i]); end
        end
        in_val = '0;
        for (int t = 0; t < 15; t++) begin
            to_neg();
            n_checks++; if (out_val !== exp_val || (exp_val && out_msg !== exp_msg))
                begin n_fail++; $display("FAIL rr_drain t=%0d got=%b/%h exp=%b/%h", t, out_val, out_msg, exp_val, exp_msg); end
            to_next();
        end
    endtask

    task automatic test_backpressure();
        msg_t pushed[$];
        msg_t m;
        out_rdy = 1'b0;
        for (int t = 0; t < D; t++) begin
            m = mk_msg(1);
            in_val = 3'b010; in_msg[1] = m;
            to_neg();
            n_checks++; if (in_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL bp_fill_rdy t=%0d got=%b exp=1", t, in_rdy[1]); end
            pushed.push_back(m);
            to_next();
        end
        in_val = '0;
        to_neg();
        n_checks++; if (occ[1] !== OCC_W'(D)) begin n_fail++; $display("FAIL bp_full_occ got=%0d exp=%0d", occ[1], D); end
        n_checks++; if (in_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full_rdy got=%b exp=0", in_rdy[1]); end
        to_next();
        m = mk_msg(1);
        in_val = 3'b010; in_msg[1] = m; out_rdy = 1'b1;
        to_neg();
        n_checks++; if (in_rdy[1] !== 1'b1 || grant_chan !== 1 || out_msg !== pushed[0])
            begin n_fail++; $display("FAIL bp_pushpop got=%b/%0d/%h exp=1/1/%h", in_rdy[1], grant_chan, out_msg, pushed[0]); end
        void'(pushed.pop_front());
        pushed.push_back(m);
        to_next();
        in_val = '0;
        to_neg();
        n_checks++; if (occ[1] !== OCC_W'(D)) begin n_fail++; $display("FAIL bp_pushpop_occ got=%0d exp=%0d", occ[1], D); end
        for (int t = 0; t < D; t++) begin
            n_checks++; if (out_val !== 1'b1 || out_msg !== pushed[0])
                begin n_fail++; $display("FAIL bp_order t=%0d got=%b/%h exp=1/%h", t, out_val, out_msg, pushed[0]); end
            void'(pushed.pop_front());
            to_next();
            to_neg();
        end
        n_checks++; if (out_val !== 1'b0 || occ !== '0) begin n_fail++; $display("FAIL bp_empty got=%b/%h exp=0/0", out_val, occ); end
        to_next();
    endtask

    task automatic test_flush();
        msg_t m1, m2;
        out_rdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_val = 3'b011; in_msg[0] = mk_msg(0); in_msg[1] = mk_msg(1);
            to_neg(); to_next();
        end
        flush = 1'b1;
        to_neg();
        n_checks++; if (occ[0] !== 2 || occ[1] !== 2) begin n_fail++; $display("FAIL flush_pre_occ got=%0d/%0d exp=2/2", occ[0], occ[1]); end
        n_checks++; if (out_val !== 1'b0 || in_rdy !== '0) begin n_fail++; $display("FAIL flush_gate got=%b/%b exp=0/0", out_val, in_rdy); end
        to_next();
        flush = 1'b0; in_val = '0;
        to_neg();
        n_checks++; if (occ !== '0 || out_val !== 1'b0) begin n_fail++; $display("FAIL flush_after got=%h/%b exp=0/0", occ, out_val); end
        to_next();
        m1 = mk_msg(1); m2 = mk_msg(2);
        in_val = 3'b110; in_msg[1] = m1; in_msg[2] = m2; out_rdy = 1'b1;
        to_neg();
        n_checks++; if (grant_chan !== 1 || out_msg !== m1 || occ[1] !== '0)
            begin n_fail++; $display("FAIL flush_rr_bypass got=%0d/%h exp=1/%h", grant_chan, out_msg, m1); end
        to_next();
        in_val = '0;
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            in_val = 3'b001; in_msg[0] = mk_msg(0);
            to_neg(); to_next();
        end
        in_val = '0; rst = 1'b1;
        to_neg(); to_next();
        rst = 1'b0;
        to_neg();
        n_checks++; if (occ !== '0 || out_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got=%h/%b exp=0/0", occ, out_val); end
        to_next();
        out_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            to_neg();
            n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale t=%0d got=%b/%h exp=0", t, out_val, out_msg); end
            to_next();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        int           waitc [N];
        int           max_wait;
        acc = '1; max_wait = 0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int t = 0; t < 600; t++) begin
            flush   = ($urandom_range(0, 49) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!in_val[i] || acc[i]) begin
                    in_val[i] = 1'($urandom_range(0, 1));
                    in_msg[i] = mk_msg(i);
                end
            to_neg();
            n_checks++; if (out_val !== exp_val) begin n_fail++; $display("FAIL rnd_val t=%0d got=%b exp=%b", t, out_val, exp_val); end
            if (exp_val) begin
                n_checks++; if (int'(grant_chan) !== exp_win || out_msg !== exp_msg)
                    begin n_fail++; $display("FAIL rnd_msg t=%0d got=%0d/%h exp=%0d/%h", t, grant_chan, out_msg, exp_win, exp_msg); end
            end
            n_checks++; if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy t=%0d got=%b exp=%b", t, in_rdy, exp_rdy); end
            for (int i = 0; i < N; i++) begin
                n_checks++; if (occ[i] !== OCC_W'(q[i].size()))
                    begin n_fail++; $display("FAIL rnd_occ t=%0d ch=%0d got=%0d exp=%0d", t, i, occ[i], q[i].size()); end
            end
            for (int i = 0; i < N; i++) begin
                if (flush || !(q[i].size() > 0 || in_val[i])) waitc[i] = 0;
                else if (out_val && out_rdy) begin
                    if (int'(grant_chan) == i) waitc[i] = 0;
                    else waitc[i]++;
                end
                if (waitc[i] > max_wait) max_wait = waitc[i];
            end
            acc = in_val & in_rdy;
            to_next();
        end
        n_checks++; if (max_wait > N - 1) begin n_fail++; $display("FAIL rnd_starve got=%0d exp<=%0d", max_wait, N - 1); end
        flush = 1'b0; in_val = '0;
    endtask

    initial begin
        rr = 0;
        rst = 1'b1; flush = 1'b0; in_val = '0; in_msg = '0; out_rdy = 1'b0;
        #1;
        test_reset();
        test_bypass();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_merge_queue.md
# ex_merge_queue

Buffers and merges the results of `p_num_chan` execute units into a single writeback stream. Each execute unit gets its own bypassable FIFO. A round-robin arbiter picks one head per cycle to send downstream. A flush input discards all buffered results on a pipeline squash. The block sits between the execute units and the writeback stage.

## Interface
Parameters:
- `p_num_chan`, 2: number of execute-unit input channels, 2–8.
- `p_depth`, 4: entries per channel FIFO, power of two, ≥ 2.
- `p_seq_num_bits`, `p_phys_addr_bits`: taken from the `X__WIntf` instances, not overridden.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `flush`, input, 1: discard all buffered entries.
- `in[p_num_chan]`, `X__WIntf.W_intf`, bundle: per-unit result (pc, waddr, wdata, wen, seq_num, preg, ppreg, val, rdy).
- `out`, `X__WIntf.X_intf`, bundle: merged result to writeback.
- `occ[p_num_chan]`, output, $clog2(p_depth+1): per-channel FIFO occupancy.
- `grant_chan`, output, $clog2(p_num_chan): channel presented on `out` this cycle; only meaningful while `out.val` is high.

## Operation
- Per channel i:
  - The head is the FIFO head if the FIFO is non-empty.
  - Otherwise the head is `in[i]` bypassed, and it is valid only if `in[i].val`.
- Arbitration:
  - Round-robin over the valid heads.
  - The priority pointer `rr_ptr` starts at 0.
  - Starting from `rr_ptr`, the first valid head wins.
  - `out` presents the winning message. `out.val` is high if any head is valid.
- Pointer update: on an `out.val & out.rdy` handshake, `rr_ptr` becomes (winner + 1) mod `p_num_chan`. With no handshake, `rr_ptr` holds.
- Grant stability: while `out.val & !out.rdy`, the grant may change only if a higher-priority head becomes valid. The downstream stage must not depend on the message staying stable.
- Ready: `in[i].rdy = !full_i | (win_i & out.rdy)`. This allows push and pop in the same cycle when the FIFO is full.
- Push: `push_i = in[i].val & in[i].rdy & !(empty_i & win_i & out.rdy)`. A bypassed message is never also enqueued.
- Pop: `pop_i = !empty_i & win_i & out.rdy`.
- Occupancy: `occ[i]` increments on push only, decrements on pop only, and holds on both or neither.
- Flush:
  - In a cycle where `flush` is high: all `in[i].rdy` = 0, `out.val` = 0, no push, no pop.
  - On the next edge all FIFOs are empty, `occ` = 0 and `rr_ptr` = 0.
- Widths:
  - The message is the packed concatenation pc(32), waddr(5), wdata(32), wen(1), seq_num, preg, ppreg.
  - Data is passed unmodified.

## Timing
- After reset: all FIFOs empty, `occ` = 0, `rr_ptr` = 0, `out.val` = 0, `grant_chan` = 0, every `in[i].rdy` = 1.
- Bypass latency is 0 cycles (combinational `in` → `out` when the FIFO is empty and the channel wins).
- Buffered latency is ≥ 1 cycle.
- Reset or flush mid-operation takes effect at the next edge. Entries accepted in that cycle are lost by contract. The upstream stage sees `rdy` = 0 during flush.
- `rst` has priority over `flush`.
- Full FIFO with the channel winning and `out.rdy` high: accept and retire in the same cycle, and occupancy stays at `p_depth`.
- Pointers wrap modulo `p_depth`.
- Per-channel order is FIFO. Cross-channel order is arbitration order, not seq_num order.

## Structure
- The shared package holds:
  - `ex_msg_t`, parameterised by seq_num and preg widths.
  - The `rr_ptr` width function.
- Reuse the existing `Fifo` from `hw/common`, one instance per channel, generated in a loop.
- One new sub-module, `RRArbiter` (valid vector in, one-hot grant plus index out, `rr_ptr` state with an advance enable). It is reusable by other merge points.

## Test plan
- Single-channel bypass: channel 0 only, `out.rdy` = 1, stream 10 messages. Expect each message on `out` in the same cycle, `occ[0]` = 0 throughout, `grant_chan` = 0.
- Round-robin fairness: 3 channels all valid every cycle, `out.rdy` = 1. Expect the grant order 0,1,2,0,1,2,…, and each channel retires 1/3 of the messages.
- Backpressure and full:
  - `out.rdy` = 0, push 4 messages into channel 1 (`p_depth` = 4). Expect `occ[1]` = 4 and `in[1].rdy` = 0 while not winning.
  - Then raise `out.rdy`. Expect the messages in push order and simultaneous push/pop holding `occ` at 4.
- Flush:
  - Fill channels 0 and 1 with 2 entries each, assert `flush` for 1 cycle. Expect `out.val` = 0 and `rdy` = 0 that cycle, then `occ` = 0, `rr_ptr` = 0.
  - New data afterwards bypasses.
- Reset mid-stream: assert `rst` with non-empty FIFOs. Expect `out.val` = 0 and `occ` = 0 the next cycle, and no stale entry is emitted afterwards.
- Random: random `val` per channel and random `out.rdy`, checked against a scoreboard. Expect per-channel order preserved, no loss or duplication, and no starvation beyond `p_num_chan` − 1 grants.
